// File: rtl/rot_pipe.sv
// Pipelined data-dependent left/right rotator for the RC5 round datapath: one barrel level per stage.
// Optional sideband tag travels with each operand when ROT_TAG_EN is defined.
module rot_pipe #(
   parameter int W = 16
`ifdef ROT_TAG_EN
   , parameter int TAG_W = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [W-1:0]     data_i,
   input  logic [W-1:0]     n_i,
   input  logic             dir_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [W-1:0]     data_o
`ifdef ROT_TAG_EN
   ,
   input  logic [TAG_W-1:0] tag_i,
   output logic [TAG_W-1:0] tag_o
`endif
);

   localparam int LOG2W = $clog2(W);

   logic [LOG2W-1:0] vld;
   logic [LOG2W-1:0] adv;
   logic [LOG2W-1:0] dir;
   logic [W-1:0]     dat   [LOG2W];
   logic [LOG2W-1:0] amt   [LOG2W];

   logic [LOG2W-1:0] nxt_v;
   logic [LOG2W-1:0] nxt_r;
   logic [W-1:0]     nxt_d [LOG2W];
   logic [LOG2W-1:0] nxt_a [LOG2W];

   logic             unused_bits;

   function automatic logic [W-1:0] rot_step(input logic [W-1:0] x, input int unsigned k,
                                             input logic right);
      if (right)
         return (x >> k) | (x << (W - k));
      else
         return (x << k) | (x >> (W - k));
   endfunction

   // Advance chain from the output back: a stage moves if empty or if the one after it moves.
   always_comb begin
      logic c;
      adv = '0;
      c = !vld[LOG2W-1] | out_ready_i;
      adv[LOG2W-1] = c;
      for (int unsigned s = LOG2W - 1; s > 0; s--) begin
         c = !vld[s-1] | c;
         adv[s-1] = c;
      end
   end

   // Each stage applies its barrel level before the register, so the last register is the result.
   always_comb begin
      nxt_v    = {vld[LOG2W-2:0], in_valid_i};
      nxt_r    = {dir[LOG2W-2:0], dir_i};
      nxt_a[0] = n_i[LOG2W-1:0];
      nxt_d[0] = n_i[0] ? rot_step(data_i, 1, dir_i) : data_i;
      for (int unsigned s = 1; s < LOG2W; s++) begin
         nxt_a[s] = amt[s-1];
         nxt_d[s] = amt[s-1][s] ? rot_step(dat[s-1], 1 << s, dir[s-1]) : dat[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         dir <= '0;
         for (int unsigned s = 0; s < LOG2W; s++) begin
            dat[s] <= '0;
            amt[s] <= '0;
         end
      end else begin
         for (int unsigned s = 0; s < LOG2W; s++) begin
            if (adv[s]) begin
               vld[s] <= nxt_v[s];
               dir[s] <= nxt_r[s];
               dat[s] <= nxt_d[s];
               amt[s] <= nxt_a[s];
            end
         end
      end
   end

`ifdef ROT_TAG_EN
   logic [TAG_W-1:0] tag [LOG2W];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < LOG2W; s++) tag[s] <= '0;
      end else begin
         if (adv[0]) tag[0] <= tag_i;
         for (int unsigned s = 1; s < LOG2W; s++) begin
            if (adv[s]) tag[s] <= tag[s-1];
         end
      end
   end

   assign tag_o = tag[LOG2W-1];
`endif

   assign in_ready_o  = adv[0];
   assign out_valid_o = vld[LOG2W-1];
   assign data_o      = dat[LOG2W-1];

   // High rotate-amount bits and the last stage's control fields have no consumer.
   assign unused_bits = ^{n_i[W-1:LOG2W], amt[LOG2W-1], dir[LOG2W-1]};

endmodule

// File: tb/tb_rot_pipe.sv
// Scoreboard bench for rot_pipe: W=16 directed/backpressure/reset checks and a W=32 random stream.
module tb_rot_pipe;

   logic        clk;
   logic        rst;

   logic        v16, rdy16, dir16, ov16, ordy16;
   logic [15:0] d16, n16, q16;
   logic        v32, rdy32, dir32, ov32, ordy32;
   logic [31:0] d32, n32, q32;
`ifdef ROT_TAG_EN
   logic [3:0]  t16i, t16o, t32i, t32o;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned seq16 = 0;
   int unsigned seq32 = 0;
   logic        rnd32 = 0;
   logic [63:0] exp16 [$];
   logic [63:0] exp32 [$];

   rot_pipe #(.W(16)) u16 (
      .clk(clk), .rst(rst),
      .in_valid_i(v16), .in_ready_o(rdy16), .data_i(d16), .n_i(n16), .dir_i(dir16),
      .out_valid_o(ov16), .out_ready_i(ordy16), .data_o(q16)
`ifdef ROT_TAG_EN
      , .tag_i(t16i), .tag_o(t16o)
`endif
   );

   rot_pipe #(.W(32)) u32 (
      .clk(clk), .rst(rst),
      .in_valid_i(v32), .in_ready_o(rdy32), .data_i(d32), .n_i(n32), .dir_i(dir32),
      .out_valid_o(ov32), .out_ready_i(ordy32), .data_o(q32)
`ifdef ROT_TAG_EN
      , .tag_i(t32i), .tag_o(t32o)
`endif
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bit-by-bit reference rotation, independent of the barrel structure.
   function automatic logic [63:0] ref_rot(input logic [63:0] x, input int unsigned n,
                                           input logic right, input int unsigned w);
      logic [63:0] r;
      int unsigned a, j;
      r = '0;
      a = n % w;
      for (int unsigned i = 0; i < w; i++) begin
         j = right ? (i + w - a) % w : (i + a) % w;
         r[j] = x[i];
      end
      return r;
   endfunction

   function automatic logic [63:0] pk(input int unsigned tg, input logic [63:0] e);
`ifdef ROT_TAG_EN
      logic [3:0] t;
      t = tg[3:0];
      return (64'(t) << 32) | e;
`else
      return e + 64'(tg & 0);
`endif
   endfunction

   function automatic logic [63:0] got16();
`ifdef ROT_TAG_EN
      return (64'(t16o) << 32) | 64'(q16);
`else
      return 64'(q16);
`endif
   endfunction

   function automatic logic [63:0] got32();
`ifdef ROT_TAG_EN
      return (64'(t32o) << 32) | 64'(q32);
`else
      return 64'(q32);
`endif
   endfunction

   // Output monitors: pop and compare whenever a result is handed over.
   always begin
      @(negedge clk);
      #2;
      if (!rst && ov16 && ordy16) begin
         if (exp16.size() == 0) chk("sb16_extra", 64'(exp16.size()), 64'd1);
         else chk("sb16_data", got16(), exp16.pop_front());
      end
      if (!rst && ov32 && ordy32) begin
         if (exp32.size() == 0) chk("sb32_extra", 64'(exp32.size()), 64'd1);
         else chk("sb32_data", got32(), exp32.pop_front());
      end
   end

   always begin
      @(negedge clk);
      if (rnd32) ordy32 = 1'($urandom_range(0, 1));
   end

   task automatic send16(input logic [15:0] d, input logic [15:0] n, input logic r,
                         input logic [15:0] e);
      int unsigned guard;
      guard = 0;
      @(negedge clk);
      v16 = 1; d16 = d; n16 = n; dir16 = r;
`ifdef ROT_TAG_EN
      t16i = 4'(seq16);
`endif
      #1;
      while (!rdy16 && guard < 500) begin
         @(negedge clk); #1; guard++;
      end
      if (!rdy16) chk("send16_timeout", 64'(rdy16), 64'd1);
      else begin
         exp16.push_back(pk(seq16, 64'(e)));
         seq16++;
      end
      @(posedge clk); #1;
      v16 = 0;
   endtask

   task automatic send32(input logic [31:0] d, input logic [31:0] n, input logic r,
                         input logic [31:0] e);
      int unsigned guard;
      guard = 0;
      @(negedge clk);
      v32 = 1; d32 = d; n32 = n; dir32 = r;
`ifdef ROT_TAG_EN
      t32i = 4'(seq32);
`endif
      #1;
      while (!rdy32 && guard < 500) begin
         @(negedge clk); #1; guard++;
      end
      if (!rdy32) chk("send32_timeout", 64'(rdy32), 64'd1);
      else begin
         exp32.push_back(pk(seq32, 64'(e)));
         seq32++;
      end
      @(posedge clk); #1;
      v32 = 0;
   endtask

   task automatic drain16();
      int unsigned guard;
      guard = 0;
      while (exp16.size() != 0 && guard < 1000) begin
         @(negedge clk); guard++;
      end
      @(negedge clk); #3;
      chk("drain16", 64'(exp16.size()), 64'd0);
   endtask

   task automatic drain32();
      int unsigned guard;
      guard = 0;
      while (exp32.size() != 0 && guard < 5000) begin
         @(negedge clk); guard++;
      end
      @(negedge clk); #3;
      chk("drain32", 64'(exp32.size()), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a16, b16;
      logic        r;
      logic [31:0] a32, b32;
      int unsigned lat;

      rst = 1;
      v16 = 0; d16 = '0; n16 = '0; dir16 = 0; ordy16 = 1;
      v32 = 0; d32 = '0; n32 = '0; dir32 = 0; ordy32 = 1;
`ifdef ROT_TAG_EN
      t16i = '0; t32i = '0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      chk("rst_ov16", 64'(ov16), 64'd0);
      chk("rst_q16", got16(), 64'd0);
      chk("rst_rdy16", 64'(rdy16), 64'd1);
      chk("rst_ov32", 64'(ov32), 64'd0);
      chk("rst_q32", got32(), 64'd0);
      chk("rst_rdy32", 64'(rdy32), 64'd1);

      // Latency: accepted at edge k, valid after edge k+3 for W=16.
      send16(16'h5555, 16'd1, 1'b0, 16'hAAAA);
      lat = 1;
      while (!ov16 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency16", 64'(lat), 64'd4);
      drain16();

      send16(16'h5555, 16'd17, 1'b0, 16'hAAAA);
      send16(16'h5555, 16'd16, 1'b0, 16'h5555);
      send16(16'h1234, 16'd4, 1'b1, 16'h4123);
      send16(16'h1234, 16'd4, 1'b0, 16'h2341);
      send16(16'h8001, 16'hFFF0, 1'b1, 16'h8001);
      drain16();

      // Backpressure: four operands fill the pipe, the fifth waits.
      ordy16 = 0;
      for (int i = 0; i < 4; i++) begin
         a16 = 16'($urandom); b16 = 16'($urandom); r = 1'($urandom_range(0, 1));
         send16(a16, b16, r, 16'(ref_rot(64'(a16), 32'(b16), r, 16)));
      end
      a16 = 16'hC3A5; b16 = 16'd7; r = 1'b1;
      @(negedge clk);
      v16 = 1; d16 = a16; n16 = b16; dir16 = r;
`ifdef ROT_TAG_EN
      t16i = 4'(seq16);
`endif
      #1;
      chk("bp_full_rdy", 64'(rdy16), 64'd0);
      chk("bp_full_valid", 64'(ov16), 64'd1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); #1;
         chk("bp_stall_rdy", 64'(rdy16), 64'd0);
         chk("bp_hold", got16(), exp16[0]);
      end
      ordy16 = 1;
      #2;
      chk("bp_push_pop_rdy", 64'(rdy16), 64'd1);
      exp16.push_back(pk(seq16, ref_rot(64'(a16), 32'(b16), r, 16)));
      seq16++;
      @(posedge clk); #1;
      v16 = 0;
      a16 = 16'h0F0F;
      send16(a16, 16'd3, 1'b0, 16'h7878);
      drain16();

      // Reset with three operands in flight: none of them may surface.
      ordy16 = 0;
      for (int i = 0; i < 3; i++) send16(16'(16'h1111 * (i + 1)), 16'(i), 1'b0, 16'h0000);
      @(negedge clk);
      rst = 1;
      exp16.delete();
      @(posedge clk); #1;
      chk("midrst_ov16", 64'(ov16), 64'd0);
      chk("midrst_q16", got16(), 64'd0);
      @(negedge clk);
      rst = 0;
      ordy16 = 1;
      #1;
      chk("midrst_rdy16", 64'(rdy16), 64'd1);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk); #1;
         chk("post_rst_ov16", 64'(ov16), 64'd0);
      end
      seq16 = 0;
      for (int i = 0; i < 4; i++) begin
         a16 = 16'($urandom);
         send16(a16, 16'(i), 1'b1, 16'(ref_rot(64'(a16), 32'(i), 1'b1, 16)));
      end
      drain16();

      // W=32 directed corner, then a random stream under random output stalls.
      send32(32'h8000_0001, 32'd31, 1'b0, 32'hC000_0000);
      drain32();
      rnd32 = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         a32 = $urandom; b32 = $urandom; r = 1'($urandom_range(0, 1));
         send32(a32, b32, r, 32'(ref_rot(64'(a32), b32, r, 32)));
      end
      rnd32 = 0;
      @(negedge clk);
      ordy32 = 1;
      drain32();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
